down_timer: RTL
===============

Name: down_timer

Overview:
- Loadable down-counting timer: the counting-down counterpart to the team's free-running up counters.
- Counts from a loaded value to terminal, emits a one-cycle done pulse, and optionally auto-reloads for periodic operation.
- Used as a programmable delay and period generator in the lab datapaths.
- Count advances only on cycles where en is high, so an external prescaler tick can drive it.

Parameters:
- WIDTH, 8, width of the load value and the count.
- LAP_W, 4, width of the completed-period (lap) counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low. Asserting rst=0 clears all state immediately; release is sampled on clk.
- start  input  1  begin a count: latch load_val, enter RUN. Also restarts a count already in RUN.
- stop  input  1  abort a count in RUN; ignored in IDLE.
- en  input  1  count-enable tick; a RUN-state decrement happens only when en=1.
- auto_reload  input  1  sampled at start. 1 = periodic mode, 0 = one-shot mode.
- load_val  input  WIDTH  start/reload value N.
- cnt  output  WIDTH  current count, registered.
- busy  output  1  high while the state is RUN.
- done  output  1  one-cycle pulse on terminal count.
- laps  output  LAP_W  number of done pulses since reset; wraps modulo 2^LAP_W.

Behaviour:
- Reset (rst=0): state=IDLE, cnt=0, busy=0, done=0, laps=0, reload_reg=0, mode_reg=0. Reset mid-count abandons the count with no done pulse.
- States: IDLE, RUN. busy is registered and equals (state==RUN).
- done defaults to 0 every cycle; it is only ever high for exactly one cycle.
- IDLE, start=1, load_val!=0: cnt<=load_val, reload_reg<=load_val, mode_reg<=auto_reload, state<=RUN. busy is high the next cycle.
- IDLE, start=1, load_val==0: done<=1, cnt<=0, laps++, state stays IDLE regardless of auto_reload.
- IDLE, start=0: all state holds; stop and en are ignored.
- RUN priority, highest first: stop, then start, then en-driven decrement.
- RUN, stop=1: state<=IDLE, cnt holds its value, no done pulse, laps unchanged. This applies even if start=1 or a terminal condition coincides.
- RUN, start=1 (stop=0): restart exactly as from IDLE, including the load_val==0 case. Any pending terminal in that cycle is discarded, with no done pulse.
- RUN, en=1, cnt>1: cnt<=cnt-1.
- RUN, en=1, cnt==1 (terminal): done<=1 and laps<=laps+1.
  - mode_reg=0 (one-shot): cnt<=0, state<=IDLE.
  - mode_reg=1 (periodic): cnt<=reload_reg, state stays RUN.
- RUN, en=0: all state holds.
- Latency: from start to done is exactly N en-cycles. With en tied high, done is asserted in the cycle N after the start edge.
- Periodic mode: period is exactly N en-cycles; cnt never shows 0. Changes to load_val or auto_reload mid-count take effect only at the next start.
- Arithmetic: cnt is unsigned. Decrement never underflows, because cnt==0 cannot occur in RUN. laps wraps 2^LAP_W-1 -> 0.

Decomposition:
- Shared package holds the state enum (IDLE, RUN) as a 1-bit typedef.
- No sub-module: one FSM plus its datapath registers, with no natural split.

Test Plan:
- Reset: rst=0 asserted mid-RUN with cnt=5 -> cnt=0, busy=0, done=0, laps=0 immediately, without waiting for a clock edge.
- One-shot: WIDTH=8, en=1, auto_reload=0, start with load_val=4 -> cnt 4,3,2,1,0 on successive cycles; done high one cycle, coincident with cnt=0; busy drops that cycle; laps=1.
- Periodic with gated en: load_val=3, auto_reload=1, en high every other cycle -> done pulses every 6 clk cycles; cnt cycles 3,2,1,3,...; after 16 pulses laps wraps to 0.
- Stop and restart: stop at cnt=2 -> IDLE, cnt holds 2, no done. Start with load_val=7 while RUN at cnt=1 with en=1 -> no done, cnt=7, still RUN.
- Simultaneous events: stop+start+terminal in the same RUN cycle -> IDLE, cnt=1, no done, laps unchanged. start with load_val=0 -> single done pulse, cnt=0, busy stays 0.
- en hold: en=0 for 10 cycles in RUN at cnt=5 -> cnt stays 5, busy=1, done=0.

Source files
------------

// File: rtl/down_timer_pkg.sv
// rtl/down_timer_pkg.sv - shared types for the loadable down-counting timer
package down_timer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/down_timer.sv
// rtl/down_timer.sv - loadable down-counting timer with one-cycle done pulse and auto-reload
module down_timer
  import down_timer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             done,
  output logic [LAP_W-1:0] laps
);

  state_t           state;
  logic [WIDTH-1:0] reload_reg;
  logic             mode_reg;

  logic in_run;
  logic abort;
  logic restart;
  logic tick;
  logic terminal;
  logic zero_load;

  // Priority in RUN is stop, then start, then the en-driven decrement.
  assign in_run    = (state == ST_RUN);
  assign abort     = in_run && stop;
  assign restart   = start && !abort;
  assign tick      = in_run && en && !stop && !start;
  assign terminal  = (cnt == WIDTH'(1));
  assign zero_load = (load_val == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      laps       <= '0;
      reload_reg <= '0;
      mode_reg   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else if (restart) begin
        if (zero_load) begin
          // A zero-length count finishes immediately and never enters RUN.
          done  <= 1'b1;
          cnt   <= '0;
          laps  <= laps + LAP_W'(1);
          state <= ST_IDLE;
          busy  <= 1'b0;
        end else begin
          cnt        <= load_val;
          reload_reg <= load_val;
          mode_reg   <= auto_reload;
          state      <= ST_RUN;
          busy       <= 1'b1;
        end
      end else if (tick) begin
        if (terminal) begin
          done <= 1'b1;
          laps <= laps + LAP_W'(1);
          if (mode_reg) begin
            cnt <= reload_reg;
          end else begin
            cnt   <= '0;
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end else begin
          cnt <= cnt - WIDTH'(1);
        end
      end
    end
  end

endmodule
